// File: rtl/br_pkg.sv
// Shared branch-predictor types: the 2-bit saturating counter encoding and its
// next-state function, reused by every predictor table in the fetch unit.
package br_pkg;

   typedef logic [1:0] ctr2_t;

   localparam ctr2_t CTR_SNT = 2'b00;
   localparam ctr2_t CTR_WNT = 2'b01;
   localparam ctr2_t CTR_WT  = 2'b10;
   localparam ctr2_t CTR_ST  = 2'b11;

   // Saturating step: taken moves toward CTR_ST, not-taken toward CTR_SNT.
   function automatic ctr2_t ctr_next(input ctr2_t ctr, input logic taken);
      ctr2_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != CTR_ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) nxt = ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/br_ghr.sv
// Global history register. It shifts in each resolved outcome, so the history
// is non-speculative and moves only when execute reports a branch.
module br_ghr #(
   parameter int HIST_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_upd_vld,
   input  logic              i_upd_taken,
   output logic [HIST_W-1:0] o_ghr
);

   logic [HIST_W-1:0] r_ghr;

   generate
      if (HIST_W == 1) begin : g_single
         // A one-bit history just remembers the most recent outcome.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_ghr <= '0;
            else if (i_upd_vld) r_ghr <= i_upd_taken;
         end
      end else begin : g_shift
         // Newest outcome enters at bit 0; the oldest falls off the top.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_ghr <= '0;
            else if (i_upd_vld) r_ghr <= {r_ghr[HIST_W-2:0], i_upd_taken};
         end
      end
   endgenerate

   assign o_ghr = r_ghr;

endmodule

// File: rtl/br_gshare_pht.sv
// Gshare pattern-history table. Fetch indexes the table with PC XOR global
// history and gets a registered direction one cycle later; execute returns the
// index with the resolved outcome to train the counter and the history.
module br_gshare_pht
   import br_pkg::*;
#(
   parameter int PC_W   = 16,
   parameter int IDX_W  = 6,
   parameter int HIST_W = 4,
   parameter int MISS_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lookup_vld,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              pred_vld,
   output logic              pred_take,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              upd_vld,
   input  logic [IDX_W-1:0]  upd_idx,
   input  logic              upd_taken,
   input  logic              upd_pred,
   output logic              mispredict,
   output logic [HIST_W-1:0] ghr,
   output logic [MISS_W-1:0] miss_cnt
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [HIST_W-1:0] w_ghr;
   logic [IDX_W-1:0]  w_idx;
   ctr2_t             w_ctrNext [ENTRIES];
   ctr2_t             w_lookCtr;
   logic              w_missEvent;
   logic              w_unusedPc;

   ctr2_t             r_ctr [ENTRIES];
   logic              r_predVld;
   logic              r_predTake;
   logic [IDX_W-1:0]  r_predIdx;
   logic              r_mispredict;
   logic [MISS_W-1:0] r_missCnt;

   br_ghr #(.HIST_W(HIST_W)) u_ghr (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_upd_vld   (upd_vld),
      .i_upd_taken (upd_taken),
      .o_ghr       (w_ghr)
   );

   // Instructions are word aligned, so the low PC bits carry no information;
   // upper bits beyond the index are simply not part of the hash.
   assign w_unusedPc = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0]};

   // Lookup hashes with the history as it stands before any same-cycle update.
   assign w_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(w_ghr);

   // Per-entry next value: only the entry named by the update moves.
   generate
      for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
         assign w_ctrNext[g] = (upd_vld && (upd_idx == IDX_W'(g)))
                               ? ctr_next(r_ctr[g], upd_taken)
                               : r_ctr[g];
      end
   endgenerate

   // Reading the next-state array gives write-through bypass for free.
   assign w_lookCtr   = w_ctrNext[w_idx];
   assign w_missEvent = upd_vld & (upd_taken ^ upd_pred);

   // Counter table; every entry starts strongly taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= CTR_ST;
      end else begin
         for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= w_ctrNext[i];
      end
   end

   // Registered prediction; direction and index hold between lookups.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_predVld  <= 1'b0;
         r_predTake <= 1'b0;
         r_predIdx  <= '0;
      end else begin
         r_predVld <= lookup_vld;
         if (lookup_vld) begin
            r_predTake <= w_lookCtr[1];
            r_predIdx  <= w_idx;
         end
      end
   end

   // Mispredict pulse and saturating statistics counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mispredict <= 1'b0;
         r_missCnt    <= '0;
      end else begin
         r_mispredict <= w_missEvent;
         if (w_missEvent && (r_missCnt != '1)) r_missCnt <= r_missCnt + 1'b1;
      end
   end

   assign pred_vld   = r_predVld;
   assign pred_take  = r_predTake;
   assign pred_idx   = r_predIdx;
   assign mispredict = r_mispredict;
   assign ghr        = w_ghr;
   assign miss_cnt   = r_missCnt;

endmodule

// File: tb/tb_br_gshare_pht.sv
// Bench for the gshare table: a behavioural model produces expected outputs
// as stimulus is driven, queues them, and compares them one cycle later.
module tb_br_gshare_pht;

   localparam int PC_W   = 16;
   localparam int IDX_W  = 6;
   localparam int HIST_W = 4;
   localparam int MISS_W = 4;

   logic              clk;
   logic              rst_n;
   logic              lookupVld;
   logic [PC_W-1:0]   lookupPc;
   logic              predVld;
   logic              predTake;
   logic [IDX_W-1:0]  predIdx;
   logic              updVld;
   logic [IDX_W-1:0]  updIdx;
   logic              updTaken;
   logic              updPred;
   logic              mispredict;
   logic [HIST_W-1:0] ghr;
   logic [MISS_W-1:0] missCnt;

   typedef struct {
      logic             vld;
      logic             take;
      logic [IDX_W-1:0] idx;
      logic             miss;
   } exp_t;

   exp_t              expQ [$];
   logic [1:0]        modelCtr [64];
   logic [HIST_W-1:0] modelGhr;
   logic [MISS_W-1:0] modelMiss;
   logic              heldTake;
   logic [IDX_W-1:0]  heldIdx;
   int                checkCount;
   int                failCount;

   br_gshare_pht #(
      .PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W), .MISS_W(MISS_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .lookup_vld (lookupVld),
      .lookup_pc  (lookupPc),
      .pred_vld   (predVld),
      .pred_take  (predTake),
      .pred_idx   (predIdx),
      .upd_vld    (updVld),
      .upd_idx    (updIdx),
      .upd_taken  (updTaken),
      .upd_pred   (updPred),
      .mispredict (mispredict),
      .ghr        (ghr),
      .miss_cnt   (missCnt)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] modelStep(input logic [1:0] c, input logic taken);
      if (taken) return (c == 2'd3) ? c : c + 2'd1;
      else       return (c == 2'd0) ? c : c - 2'd1;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) modelCtr[i] = 2'b11;
      modelGhr  = '0;
      modelMiss = '0;
      heldTake  = 1'b0;
      heldIdx   = '0;
      expQ.delete();
   endtask

   // Compare every observable output against the oldest queued expectation.
   task automatic checkCycle();
      exp_t e;
      if (expQ.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = expQ.pop_front();
      checkOutput("pred_vld", predVld, e.vld);
      if (e.vld) begin
         heldTake = e.take;
         heldIdx  = e.idx;
      end
      checkOutput("pred_take", predTake, heldTake);
      checkOutput("pred_idx", predIdx, heldIdx);
      checkOutput("mispredict", mispredict, e.miss);
      checkOutput("ghr", ghr, modelGhr);
      checkOutput("miss_cnt", missCnt, modelMiss);
   endtask

   // Drive one cycle of lookup/update, push the model's expectation, check.
   task automatic applyStimulus(input logic lkVld, input logic [PC_W-1:0] pc,
                                input logic uVld, input logic [IDX_W-1:0] uIdx,
                                input logic uTaken, input logic uPred);
      exp_t             e;
      logic [IDX_W-1:0] idx;
      @(negedge clk);
      lookupVld = lkVld;
      lookupPc  = pc;
      updVld    = uVld;
      updIdx    = uIdx;
      updTaken  = uTaken;
      updPred   = uPred;
      idx = pc[7:2] ^ {2'b00, modelGhr};
      if (uVld) begin
         modelCtr[uIdx] = modelStep(modelCtr[uIdx], uTaken);
         modelGhr = {modelGhr[HIST_W-2:0], uTaken};
         if ((uTaken != uPred) && (modelMiss != 4'hF)) modelMiss = modelMiss + 4'd1;
      end
      e.vld  = lkVld;
      e.take = modelCtr[idx][1];
      e.idx  = idx;
      e.miss = uVld && (uTaken != uPred);
      expQ.push_back(e);
      @(posedge clk);
      #1;
      checkCycle();
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      checkCount = 0;
      failCount  = 0;
      lookupVld  = 1'b0;
      lookupPc   = '0;
      updVld     = 1'b0;
      updIdx     = '0;
      updTaken   = 1'b0;
      updPred    = 1'b0;
      modelReset();

      // Power-on reset
      rst_n = 1'b0;
      #12;
      checkOutput("reset_pred_vld", predVld, 0);
      checkOutput("reset_pred_take", predTake, 0);
      checkOutput("reset_pred_idx", predIdx, 0);
      checkOutput("reset_ghr", ghr, 0);
      checkOutput("reset_miss_cnt", missCnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // First lookup: PC 0x40 maps to entry 0x10, strongly taken
      applyStimulus(1'b1, 16'h0040, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("first_idx", predIdx, 6'h10);
      checkOutput("first_take", predTake, 1);

      // Two not-taken mispredicts on entry 0x10 then look it up again
      applyStimulus(1'b0, '0, 1'b1, 6'h10, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 6'h10, 1'b0, 1'b1);
      applyStimulus(1'b1, 16'h0040, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("weak_nt_take", predTake, 0);
      checkOutput("two_misses", missCnt, 2);

      // Three correct taken updates build history 0111
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 6'h05, 1'b1, 1'b1);
      checkOutput("ghr_0111", ghr, 4'b0111);
      applyStimulus(1'b1, 16'h0040, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("hashed_idx", predIdx, 6'h17);

      // Clear history with not-taken updates elsewhere, then same-cycle bypass
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 6'h20, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0040, 1'b1, 6'h10, 1'b1, 1'b0);
      checkOutput("bypass_take", predTake, 1);
      applyStimulus(1'b1, 16'h0044, 1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 6'h10, 1'b0, 1'b1);
      applyStimulus(1'b1, 16'h0048, 1'b0, '0, 1'b0, 1'b0);
      checkOutput("after_bypass_drop", predTake, 0);

      // Saturate the mispredict counter with lookups interleaved
      for (int i = 0; i < 20; i++)
         applyStimulus(i[0], 16'(i * 4), 1'b1, 6'(i), i[1], ~i[1]);
      checkOutput("miss_saturated", missCnt, 4'hF);
      idleCycle();
      checkOutput("miss_held", missCnt, 4'hF);

      // Random mix of lookups and updates
      for (int i = 0; i < 60; i++)
         applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                       6'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Asynchronous reset mid-stream, away from any clock edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      lookupVld = 1'b0;
      updVld = 1'b0;
      #1;
      checkOutput("async_pred_vld", predVld, 0);
      checkOutput("async_pred_take", predTake, 0);
      checkOutput("async_pred_idx", predIdx, 0);
      checkOutput("async_mispredict", mispredict, 0);
      checkOutput("async_ghr", ghr, 0);
      checkOutput("async_miss_cnt", missCnt, 0);
      modelReset();
      #10;
      @(negedge clk);
      rst_n = 1'b1;
      idleCycle();

      // Every entry must be strongly taken again
      for (int i = 0; i < 64; i++) applyStimulus(1'b1, 16'(i * 4), 1'b0, '0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
